// File: rtl/vector_control_sequencer_if.sv
// rtl/vector_control_sequencer_if.sv - instruction/beat bus of the vector control sequencer; `vl` exists only with VCS_TAIL_MASK_EN
interface vector_control_sequencer_if #(
    parameter int VLEN  = 16,
    parameter int LANES = 4
);
    localparam int BEATS  = VLEN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (VLEN > 1) ? $clog2(VLEN) : 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
`ifdef VCS_TAIL_MASK_EN
    logic [$clog2(VLEN+1)-1:0] vl;
`endif
    logic             out_valid;
    logic             out_ready;
    logic             RegWrite;
    logic             ALUSrc;
    logic             MemWrite;
    logic             ResultSrc;
    logic             Branch;
    logic             vectorial;
    logic [1:0]       ImmSrc;
    logic [2:0]       ALUControl;
    logic [BEAT_W-1:0] beat_idx;
    logic [IDX_W-1:0] elem_base;
    logic [LANES-1:0] lane_mask;
    logic             last_beat;

    modport master (
        output flush, in_valid, Op, funct3, funct7, out_ready,
`ifdef VCS_TAIL_MASK_EN
        output vl,
`endif
        input  in_ready, out_valid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, vectorial,
               ImmSrc, ALUControl, beat_idx, elem_base, lane_mask, last_beat
    );

    modport slave (
        input  flush, in_valid, Op, funct3, funct7, out_ready,
`ifdef VCS_TAIL_MASK_EN
        input  vl,
`endif
        output in_ready, out_valid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, vectorial,
               ImmSrc, ALUControl, beat_idx, elem_base, lane_mask, last_beat
    );
endinterface

// File: rtl/vector_control_sequencer.sv
// rtl/vector_control_sequencer.sv - decoders plus handshake/beat sequencer; VCS_TAIL_MASK_EN enables vl-driven tail masking
module main_decoder (
    input  logic [3:0] Op,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       ResultSrc,
    output logic       Branch,
    output logic       vectorial,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp
);
    // Op[3] marks the vector form, Op[2:0] picks the instruction class
    always_comb begin
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = 1'b0;
        Branch    = 1'b0;
        ImmSrc    = 2'b00;
        ALUOp     = 2'b00;
        vectorial = Op[3];
        case (Op[2:0])
            3'b000: begin RegWrite = 1'b1; ALUOp = 2'b10; end
            3'b001: begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUOp = 2'b10; end
            3'b010: begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 1'b1; end
            3'b011: begin ALUSrc = 1'b1; MemWrite = 1'b1; ImmSrc = 2'b01; end
            3'b100: begin Branch = 1'b1; ImmSrc = 2'b10; ALUOp = 2'b01; end
            3'b101: begin RegWrite = 1'b1; ALUSrc = 1'b1; ImmSrc = 2'b11; end
            default: ;
        endcase
    end
endmodule

module alu_decoder (
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       rtype,
    output logic [2:0] ALUControl
);
    // ALUOp selects add/sub directly or defers to funct3 for arithmetic ops
    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (rtype && funct7 == 7'b0100000) ? 3'b001 : 3'b000;
                    3'b111:  ALUControl = 3'b010;
                    3'b110:  ALUControl = 3'b011;
                    3'b100:  ALUControl = 3'b100;
                    3'b010:  ALUControl = 3'b101;
                    3'b001:  ALUControl = 3'b110;
                    3'b101:  ALUControl = 3'b111;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end
endmodule

module vector_control_sequencer #(
    parameter int VLEN  = 16,
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst,
    vector_control_sequencer_if.slave bus
);
    localparam int BEATS   = VLEN / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W   = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int LANE_SH = (LANES > 1) ? $clog2(LANES) : 0;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    logic [BEAT_W-1:0] last_idx;
    logic              accept;
    logic              retire;

    logic              dec_reg_write, dec_alu_src, dec_mem_write, dec_result_src;
    logic              dec_branch, dec_vectorial;
    logic [1:0]        dec_imm_src, dec_alu_op;
    logic [2:0]        dec_alu_control;

    logic [BEAT_W-1:0] start_last_idx;
    logic [LANES-1:0]  start_mask;
    logic              start_we_ok;
    logic [BEAT_W-1:0] next_idx;
    logic [LANES-1:0]  next_mask;

`ifdef VCS_TAIL_MASK_EN
    localparam int VL_W = $clog2(VLEN + 1);
    logic [VL_W-1:0]   vl_c;
    logic [VL_W-1:0]   vl_q;

    function automatic logic [LANES-1:0] mask_upto(input int active);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) m[i] = (i < active);
        return m;
    endfunction
`endif

    function automatic logic [IDX_W-1:0] base_of(input logic [BEAT_W-1:0] b);
        return IDX_W'(32'(b) << LANE_SH);
    endfunction

    main_decoder u_main_decoder (
        .Op        (bus.Op),
        .RegWrite  (dec_reg_write),
        .ALUSrc    (dec_alu_src),
        .MemWrite  (dec_mem_write),
        .ResultSrc (dec_result_src),
        .Branch    (dec_branch),
        .vectorial (dec_vectorial),
        .ImmSrc    (dec_imm_src),
        .ALUOp     (dec_alu_op)
    );

    alu_decoder u_alu_decoder (
        .ALUOp      (dec_alu_op),
        .funct3     (bus.funct3),
        .funct7     (bus.funct7),
        .rtype      (bus.Op[2:0] == 3'b000),
        .ALUControl (dec_alu_control)
    );

    assign bus.in_ready = !bus.flush &&
                          ((state == IDLE) || (bus.out_valid && bus.out_ready && bus.last_beat));
    assign accept   = bus.in_valid && bus.in_ready;
    assign retire   = bus.out_valid && bus.out_ready;
    assign next_idx = bus.beat_idx + BEAT_W'(1);

    // Beat plan of the offered instruction: how many beats and the mask of its first beat
    always_comb begin
        start_last_idx = '0;
        start_mask     = LANES'(1);
        start_we_ok    = 1'b1;
`ifdef VCS_TAIL_MASK_EN
        vl_c = (bus.vl > VL_W'(VLEN)) ? VL_W'(VLEN) : bus.vl;
        if (dec_vectorial) begin
            if (vl_c == '0) begin
                start_mask  = '0;
                start_we_ok = 1'b0;
            end else begin
                start_last_idx = BEAT_W'(((int'(vl_c) + LANES - 1) >> LANE_SH) - 1);
                start_mask     = mask_upto(int'(vl_c));
            end
        end
`else
        if (dec_vectorial) begin
            start_last_idx = BEAT_W'(BEATS - 1);
            start_mask     = '1;
        end
`endif
    end

    // Mask for the following beat: only the tail beat of a short vector is partial
    always_comb begin
`ifdef VCS_TAIL_MASK_EN
        next_mask = mask_upto(int'(vl_q) - int'(base_of(next_idx)));
`else
        next_mask = bus.lane_mask;
`endif
    end

    // Handshake FSM: accept loads a decoded instruction, retire steps its beats, flush/reset drop it
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_idx       <= '0;
            bus.out_valid  <= 1'b0;
            bus.RegWrite   <= 1'b0;
            bus.ALUSrc     <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.ResultSrc  <= 1'b0;
            bus.Branch     <= 1'b0;
            bus.vectorial  <= 1'b0;
            bus.ImmSrc     <= '0;
            bus.ALUControl <= '0;
            bus.beat_idx   <= '0;
            bus.elem_base  <= '0;
            bus.lane_mask  <= '0;
            bus.last_beat  <= 1'b0;
`ifdef VCS_TAIL_MASK_EN
            vl_q           <= '0;
`endif
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            state          <= ISSUE;
            last_idx       <= start_last_idx;
            bus.out_valid  <= 1'b1;
            bus.RegWrite   <= dec_reg_write & start_we_ok;
            bus.ALUSrc     <= dec_alu_src;
            bus.MemWrite   <= dec_mem_write & start_we_ok;
            bus.ResultSrc  <= dec_result_src;
            bus.Branch     <= dec_branch;
            bus.vectorial  <= dec_vectorial;
            bus.ImmSrc     <= dec_imm_src;
            bus.ALUControl <= dec_alu_control;
            bus.beat_idx   <= '0;
            bus.elem_base  <= '0;
            bus.lane_mask  <= start_mask;
            bus.last_beat  <= (start_last_idx == '0);
`ifdef VCS_TAIL_MASK_EN
            vl_q           <= vl_c;
`endif
        end else if (retire) begin
            if (bus.last_beat) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
            end else begin
                bus.beat_idx  <= next_idx;
                bus.elem_base <= base_of(next_idx);
                bus.lane_mask <= next_mask;
                bus.last_beat <= (next_idx == last_idx);
            end
        end
    end
endmodule

// File: tb/tb_vector_control_sequencer.sv
// tb/tb_vector_control_sequencer.sv - randomized scoreboard bench for vector_control_sequencer
module tb_vector_control_sequencer;
    localparam int VLEN   = 16;
    localparam int LANES  = 4;
    localparam int BEATS  = VLEN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int FW     = 11 + BEAT_W + IDX_W + LANES + 1;

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3;
    localparam logic [2:0] A_XOR = 3'd4, A_SLT = 3'd5, A_SLL = 3'd6, A_SRL = 3'd7;

    typedef struct {
        logic [10:0] ctrl;
        int          idx;
        int          base;
        int          mask;
        bit          last;
    } beat_t;

    logic  clk;
    logic  rst;
    int    checks;
    int    failures;
    int    n_acc;
    beat_t exp_q[$];

    vector_control_sequencer_if #(.VLEN(VLEN), .LANES(LANES)) bus ();

    vector_control_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] alu_fn(input logic [2:0] f3, input bit sub);
        case (f3)
            3'd0:    return sub ? A_SUB : A_ADD;
            3'd7:    return A_AND;
            3'd6:    return A_OR;
            3'd4:    return A_XOR;
            3'd2:    return A_SLT;
            3'd1:    return A_SLL;
            3'd5:    return A_SRL;
            default: return A_ADD;
        endcase
    endfunction

    // {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, vectorial, ImmSrc, ALUControl}
    function automatic logic [10:0] ref_ctrl(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic rw, src, mw, rs, br;
        logic [1:0] imm;
        logic [2:0] alu;
        rw = 0; src = 0; mw = 0; rs = 0; br = 0; imm = 2'd0; alu = A_ADD;
        case (op[2:0])
            3'd0: begin rw = 1; alu = alu_fn(f3, f7 == 7'b0100000); end
            3'd1: begin rw = 1; src = 1; alu = alu_fn(f3, 1'b0); end
            3'd2: begin rw = 1; src = 1; rs = 1; end
            3'd3: begin src = 1; mw = 1; imm = 2'd1; end
            3'd4: begin br = 1; imm = 2'd2; alu = A_SUB; end
            3'd5: begin rw = 1; src = 1; imm = 2'd3; end
            default: ;
        endcase
        return {rw, src, mw, rs, br, op[3], imm, alu};
    endfunction

    // Expected beats of one instruction, appended to the scoreboard
    task automatic push_instr(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [10:0] c;
        int v, nb, act;
        c = ref_ctrl(op, f3, f7);
        if (!op[3]) begin
            exp_q.push_back('{ctrl: c, idx: 0, base: 0, mask: 1, last: 1'b1});
            return;
        end
`ifdef VCS_TAIL_MASK_EN
        v = (int'(bus.vl) > VLEN) ? VLEN : int'(bus.vl);
        if (v == 0) begin
            c[10] = 1'b0;
            c[8]  = 1'b0;
            exp_q.push_back('{ctrl: c, idx: 0, base: 0, mask: 0, last: 1'b1});
            return;
        end
`else
        v = VLEN;
`endif
        nb = (v + LANES - 1) / LANES;
        for (int k = 0; k < nb; k++) begin
            act = v - k * LANES;
            if (act > LANES) act = LANES;
            exp_q.push_back('{ctrl: c, idx: k, base: k * LANES, mask: (1 << act) - 1, last: (k == nb - 1)});
        end
    endtask

    function automatic logic exp_in_ready();
        return !bus.flush && (exp_q.size() == 0 || (bus.out_ready && exp_q.size() == 1));
    endfunction

    function automatic logic [FW-1:0] obs_fields();
        return {bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.ResultSrc, bus.Branch, bus.vectorial,
                bus.ImmSrc, bus.ALUControl, bus.beat_idx, bus.elem_base, bus.lane_mask, bus.last_beat};
    endfunction

    function automatic logic [FW+1:0] obs_vec();
        return {bus.out_valid, bus.in_ready, bus.out_valid ? obs_fields() : FW'(0)};
    endfunction

    function automatic logic [FW+1:0] exp_vec();
        beat_t b;
        if (exp_q.size() == 0) return {1'b0, exp_in_ready(), FW'(0)};
        b = exp_q[0];
        return {1'b1, exp_in_ready(), b.ctrl, BEAT_W'(b.idx), IDX_W'(b.base), LANES'(b.mask), b.last};
    endfunction

    // Advance the reference model by the edge about to happen, then step past it
    task automatic tick();
        bit acc;
        acc = bus.in_valid && exp_in_ready();
        if (rst || bus.flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
            if (acc) begin
                push_instr(bus.Op, bus.funct3, bus.funct7);
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op);
        bus.Op     = op;
        bus.funct3 = 3'($urandom);
        bus.funct7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
    endtask

`ifdef VCS_TAIL_MASK_EN
    task automatic set_vl(input int v);
        bus.vl = ($clog2(VLEN + 1))'(v);
    endtask
`endif

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs_fields() !== FW'(0)) begin
            failures++;
            $display("FAIL reset_init: got valid=%b ready=%b fields=%h want 0 1 0", bus.out_valid, bus.in_ready, obs_fields());
        end
        set_instr({1'b1, 3'd0});
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_pre cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
            bus.in_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (obs_fields() !== FW'(0)) begin
            failures++;
            $display("FAIL reset_mid_fields: got %h want 0", obs_fields());
        end
        tick();
    endtask

    task automatic test_scalar_stream();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (c < 3);
            set_instr({1'b0, 3'($urandom)});
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL scalar_stream cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int start, valid_cnt;
        bit switched;
        start = n_acc; valid_cnt = 0; switched = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_instr({1'b1, 3'($urandom)});
        for (int c = 0; c < 12; c++) begin
            if (n_acc == start + 1 && !switched) begin
                set_instr({1'b1, 3'($urandom)});
                switched = 1;
            end
            if (n_acc == start + 2) bus.in_valid = 1'b0;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (bus.out_valid) valid_cnt++;
            tick();
        end
        checks++;
        if (valid_cnt != 2 * BEATS) begin
            failures++;
            $display("FAIL back_to_back_bubble: got %0d beats want %0d", valid_cnt, 2 * BEATS);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1;
        set_instr({1'b1, 3'($urandom)});
        for (int c = 0; c < 10; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_instr({1'b1, 3'($urandom)});
        for (int c = 0; c < 7; c++) begin
            bus.flush = (c == 3);
            if (c == 1) bus.in_valid = 1'b0;
            if (c == 3) begin
                bus.in_valid = 1'b1;
                set_instr({1'b1, 3'($urandom)});
            end
            if (c == 4) bus.in_valid = 1'b0;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flush cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        bus.flush = 1'b0;
    endtask

`ifdef VCS_TAIL_MASK_EN
    task automatic test_tail();
        int vls[5] = '{10, 0, 20, 7, 16};
        bus.out_ready = 1'b1;
        foreach (vls[i]) begin
            bus.in_valid = 1'b1;
            set_instr(4'b1000);
            set_vl(vls[i]);
            for (int c = 0; c < BEATS + 2; c++) begin
                #1;
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL tail vl=%0d cyc%0d: got %h want %h", vls[i], c, obs_vec(), exp_vec());
                end
                tick();
                bus.in_valid = 1'b0;
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            set_instr(4'($urandom));
`ifdef VCS_TAIL_MASK_EN
            set_vl($urandom_range(0, VLEN + 8));
`endif
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < BEATS + 1; c++) begin
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_drain cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0; n_acc = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_instr(4'b0000);
`ifdef VCS_TAIL_MASK_EN
        set_vl(VLEN);
`endif
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_scalar_stream();
        test_back_to_back();
        test_backpressure();
        test_flush();
`ifdef VCS_TAIL_MASK_EN
        test_tail();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
